// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Handshake and payload bundle between two pipeline stages.
//   slave  : the stage register itself (consumes in_*, produces out_*)
//   master : the surrounding logic (produces in_*, flush, out_ready)
// Signals:
//   flush                 synchronous kill of all held entries
//   in_valid / in_ready   upstream handshake
//   in_pc, in_instr       instruction PC and word
//   in_data               NUM_DATA packed channels, channel k at [k*DATA_W +: DATA_W]
//   in_exc, local_exc     earlier-stage and current-stage exception codes (0 = none)
//   in_bd                 branch-delay-slot flag
//   out_valid / out_ready downstream handshake
//   out_*                 head entry fields
//   out_count             entries held (0..2)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 4,
    parameter int unsigned EXC_W    = 5
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_pc;
    logic [31:0]                in_instr;
    logic [NUM_DATA*DATA_W-1:0] in_data;
    logic [EXC_W-1:0]           in_exc;
    logic [EXC_W-1:0]           local_exc;
    logic                       in_bd;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_pc;
    logic [31:0]                out_instr;
    logic [NUM_DATA*DATA_W-1:0] out_data;
    logic [EXC_W-1:0]           out_exc;
    logic                       out_bd;
    logic [1:0]                 out_count;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_data, in_exc, local_exc, in_bd, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_data, out_exc, out_bd, out_count
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, in_data, in_exc, local_exc, in_bd, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_data, out_exc, out_bd, out_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register used at every stage boundary of the MIPS core
// (D/E, E/M, M/W). Valid/ready handshake, optional two-entry skid buffer,
// synchronous flush that leaves a NOP bubble, and exception-code merging
// where an exception from an earlier stage wins over the local one.
// Ports:
//   clk    stage clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    pipe_stage_reg_if.slave (handshake, payload, flush, out_count)
// Parameters:
//   DATA_W, NUM_DATA  data channel width / count
//   EXC_W             exception code width
//   SKID              1: two entries, registered in_ready; 0: one entry,
//                     in_ready = !out_valid | out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 4,
    parameter int unsigned EXC_W    = 5,
    parameter int unsigned SKID     = 1
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);
    localparam int unsigned DW = NUM_DATA * DATA_W;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [DW-1:0]    data;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } entry_t;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e r_state;
    logic   r_in_ready;
    entry_t r_main;
    entry_t r_skid;

    logic   w_out_valid;
    logic   w_in_ready;
    logic   w_in_fire;
    logic   w_out_fire;
    entry_t w_in_entry;

    assign w_out_valid = (r_state != StEmpty);
    // With the skid buffer in_ready comes straight from a flop, so there is
    // no combinational path from out_ready back upstream.
    assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || bus.out_ready);
    assign w_in_fire   = bus.in_valid && w_in_ready && !bus.flush;
    assign w_out_fire  = w_out_valid && bus.out_ready;

    always_comb begin
        w_in_entry.pc    = bus.in_pc;
        w_in_entry.instr = bus.in_instr;
        w_in_entry.data  = bus.in_data;
        // An exception raised by an earlier instruction stage takes priority.
        w_in_entry.exc   = (bus.in_exc != '0) ? bus.in_exc : bus.local_exc;
        w_in_entry.bd    = bus.in_bd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (bus.flush) begin
            // Bubble keeps pc/bd so CP0 still sees a meaningful EPC/BD.
            r_state      <= StEmpty;
            r_in_ready   <= 1'b1;
            r_main.instr <= '0;
            r_main.data  <= '0;
            r_main.exc   <= '0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        r_main  <= w_in_entry;
                        r_state <= StOne;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_entry;
                    end else if (w_in_fire && (SKID != 0)) begin
                        r_skid     <= w_in_entry;
                        r_state    <= StFull;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        // Empty head reads as a NOP; pc/bd are left alone.
                        r_main.instr <= '0;
                        r_main.data  <= '0;
                        r_main.exc   <= '0;
                        r_state      <= StEmpty;
                    end
                end
                StFull: begin
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_state    <= StOne;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StEmpty;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_count = r_state;
    assign bus.out_pc    = r_main.pc;
    assign bus.out_instr = r_main.instr;
    assign bus.out_data  = r_main.data;
    assign bus.out_exc   = r_main.exc;
    assign bus.out_bd    = r_main.bd;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one SKID=0 and one SKID=1 instance with identical upstream traffic
// (independent out_ready) and checks both against a queue model every cycle,
// plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_DATA = 4;
    localparam int unsigned EXC_W    = 5;
    localparam int unsigned DW       = NUM_DATA * DATA_W;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [DW-1:0]    data;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .EXC_W(EXC_W)) bus0 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .EXC_W(EXC_W)) bus1 ();

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .EXC_W(EXC_W), .SKID(0)) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .EXC_W(EXC_W), .SKID(1)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 = SKID=0 instance, index 1 = SKID=1 instance.
    ent_t        mq   [2][2];
    int          mn   [2];
    logic [31:0] m_pc [2];
    logic        m_bd [2];

    initial begin
        ent_t e;
        logic ordy, rdy, fin, fout;
        for (int d = 0; d < 2; d++) begin
            mn[d] = 0; m_pc[d] = '0; m_bd[d] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int d = 0; d < 2; d++) begin
                    mn[d] = 0; m_pc[d] = '0; m_bd[d] = 1'b0;
                end
            end else begin
                e.pc    = bus0.in_pc;
                e.instr = bus0.in_instr;
                e.data  = bus0.in_data;
                e.exc   = (bus0.in_exc != '0) ? bus0.in_exc : bus0.local_exc;
                e.bd    = bus0.in_bd;
                for (int d = 0; d < 2; d++) begin
                    ordy = (d == 0) ? bus0.out_ready : bus1.out_ready;
                    rdy  = (d == 1) ? (mn[d] < 2) : (mn[d] == 0 || ordy);
                    fin  = bus0.in_valid && rdy && !bus0.flush;
                    fout = (mn[d] > 0) && ordy;
                    if (bus0.flush) begin
                        mn[d] = 0;
                    end else begin
                        if (fout) begin
                            mq[d][0] = mq[d][1];
                            mn[d]    = mn[d] - 1;
                        end
                        if (fin) begin
                            mq[d][mn[d]] = e;
                            mn[d]        = mn[d] + 1;
                        end
                    end
                    if (mn[d] > 0) begin
                        m_pc[d] = mq[d][0].pc;
                        m_bd[d] = mq[d][0].bd;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic v, input logic [1:0] cnt, input logic rdy,
                           input logic [31:0] pc, input logic [31:0] ins,
                           input logic [DW-1:0] dat, input logic [EXC_W-1:0] ex,
                           input logic bd, input logic ordy);
        ent_t  h;
        logic  exp_rdy;
        string p;
        p = (d == 0) ? "skid0" : "skid1";
        h = '0;
        if (mn[d] > 0) h = mq[d][0];
        exp_rdy = (d == 1) ? (mn[d] < 2) : (mn[d] == 0 || ordy);
        chk({p, ".out_valid"}, DW'(v), DW'(mn[d] > 0));
        chk({p, ".out_count"}, DW'(cnt), DW'(mn[d]));
        chk({p, ".in_ready"}, DW'(rdy), DW'(exp_rdy));
        chk({p, ".out_pc"}, DW'(pc), DW'(m_pc[d]));
        chk({p, ".out_instr"}, DW'(ins), DW'(h.instr));
        chk({p, ".out_data"}, dat, h.data);
        chk({p, ".out_exc"}, DW'(ex), DW'(h.exc));
        chk({p, ".out_bd"}, DW'(bd), DW'(m_bd[d]));
    endtask

    task automatic compare_all();
        cmp_dut(0, bus0.out_valid, bus0.out_count, bus0.in_ready, bus0.out_pc, bus0.out_instr,
                bus0.out_data, bus0.out_exc, bus0.out_bd, bus0.out_ready);
        cmp_dut(1, bus1.out_valid, bus1.out_count, bus1.in_ready, bus1.out_pc, bus1.out_instr,
                bus1.out_data, bus1.out_exc, bus1.out_bd, bus1.out_ready);
    endtask

    // Compare on the falling edge, then return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [EXC_W-1:0] ex, input logic [EXC_W-1:0] lex,
                         input logic bd, input logic fl, input logic r0, input logic r1);
        logic [DW-1:0] dat;
        dat = DW'({$urandom, $urandom, $urandom, $urandom});
        bus0.in_valid = v;   bus1.in_valid = v;
        bus0.in_pc = pc;     bus1.in_pc = pc;
        bus0.in_instr = ins; bus1.in_instr = ins;
        bus0.in_data = dat;  bus1.in_data = dat;
        bus0.in_exc = ex;    bus1.in_exc = ex;
        bus0.local_exc = lex; bus1.local_exc = lex;
        bus0.in_bd = bd;     bus1.in_bd = bd;
        bus0.flush = fl;     bus1.flush = fl;
        bus0.out_ready = r0; bus1.out_ready = r1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.valid", DW'(bus1.out_valid), DW'(0));
        chk("rst.in_ready", DW'(bus1.in_ready), DW'(1));
        chk("rst.count", DW'(bus1.out_count), DW'(0));

        // Streaming with out_ready high
        drive(1, 32'h3000, 32'h2001_0001, 0, 0, 0, 0, 1, 1);
        tick();
        chk("stream.pc0", DW'(bus1.out_pc), DW'(32'h3000));
        chk("stream.cnt0", DW'(bus1.out_count), DW'(1));
        drive(1, 32'h3004, 32'h2001_0002, 0, 0, 0, 0, 1, 1);
        tick();
        chk("stream.pc1", DW'(bus1.out_pc), DW'(32'h3004));
        chk("stream.pc1_s0", DW'(bus0.out_pc), DW'(32'h3004));
        drive(1, 32'h3008, 32'h2001_0003, 0, 0, 0, 0, 1, 1);
        tick();
        chk("stream.pc2", DW'(bus1.out_pc), DW'(32'h3008));
        chk("stream.cnt2", DW'(bus1.out_count), DW'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("stream.drain", DW'(bus1.out_valid), DW'(0));

        // Skid buffer fill / drain; SKID=0 combinational in_ready
        drive(1, 32'h3000, 32'h2002_0001, 0, 0, 0, 0, 0, 0);
        tick();
        chk("skid.rdy_one", DW'(bus1.in_ready), DW'(1));
        chk("s0.rdy_full", DW'(bus0.in_ready), DW'(0));
        drive(1, 32'h3004, 32'h2002_0002, 0, 0, 0, 0, 0, 0);
        tick();
        chk("skid.cnt_full", DW'(bus1.out_count), DW'(2));
        chk("skid.rdy_full", DW'(bus1.in_ready), DW'(0));
        chk("skid.head0", DW'(bus1.out_pc), DW'(32'h3000));
        drive(1, 32'h3004, 32'h2002_0002, 0, 0, 0, 0, 1, 0);
        #1;
        chk("s0.rdy_comb", DW'(bus0.in_ready), DW'(1));
        tick();
        chk("s0.replace", DW'(bus0.out_pc), DW'(32'h3004));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("skid.head1", DW'(bus1.out_pc), DW'(32'h3004));
        chk("skid.rdy_pop", DW'(bus1.in_ready), DW'(1));
        tick();
        chk("skid.empty_instr", DW'(bus1.out_instr), DW'(0));

        // Exception merge
        drive(1, 32'h3020, 32'h2003_0001, 5'd0, 5'd12, 0, 0, 1, 1);
        tick();
        chk("exc.local", DW'(bus1.out_exc), DW'(12));
        drive(1, 32'h3024, 32'h2003_0002, 5'd4, 5'd12, 0, 0, 1, 1);
        tick();
        chk("exc.upstream", DW'(bus1.out_exc), DW'(4));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();

        // Flush with a simultaneous input
        drive(1, 32'h3010, 32'h2108_0001, 5'd3, 5'd0, 1, 0, 0, 0);
        tick();
        drive(1, 32'h3018, 32'h2108_0002, 5'd0, 5'd0, 0, 0, 0, 0);
        tick();
        chk("flush.pre_cnt", DW'(bus1.out_count), DW'(2));
        drive(1, 32'h3014, 32'h2108_0003, 5'd0, 5'd0, 0, 1, 1, 1);
        tick();
        chk("flush.valid", DW'(bus1.out_valid), DW'(0));
        chk("flush.instr", DW'(bus1.out_instr), DW'(0));
        chk("flush.exc", DW'(bus1.out_exc), DW'(0));
        chk("flush.pc", DW'(bus1.out_pc), DW'(32'h3010));
        chk("flush.bd", DW'(bus1.out_bd), DW'(1));
        chk("flush.rdy", DW'(bus1.in_ready), DW'(1));
        chk("flush.pc_s0", DW'(bus0.out_pc), DW'(32'h3010));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        tick();
        chk("flush.lost", DW'(bus1.out_valid), DW'(0));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 3) != 0), 32'h4000 + 32'(i * 4), $urandom,
                  ($urandom_range(0, 1) != 0) ? EXC_W'(0) : EXC_W'($urandom),
                  EXC_W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        // Asynchronous reset while full
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        tick();
        tick();
        drive(1, 32'h3040, 32'h2004_0001, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h3044, 32'h2004_0002, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rstmid.full", DW'(bus1.out_count), DW'(2));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.valid", DW'(bus1.out_valid), DW'(0));
        chk("rstmid.count", DW'(bus1.out_count), DW'(0));
        chk("rstmid.instr", DW'(bus1.out_instr), DW'(0));
        chk("rstmid.rdy", DW'(bus1.in_ready), DW'(1));
        chk("rstmid.valid_s0", DW'(bus0.out_valid), DW'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 1) != 0), 32'h5000 + 32'(i * 4), $urandom,
                  EXC_W'($urandom), EXC_W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 1) != 0),
                  ($urandom_range(0, 1) != 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
